sync_span_counter: RTL and testbench

//   Parametrised line/pixel position counter; successor to the free-running saturating counter.

---
 rtl/sync_span_counter.sv | 114 +++++++++++
 tb/tb_sync_span_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sync_span_counter.sv
// sync_span_counter
//   Line/pixel position counter. It counts enabled cycles after a synchronous line
//   restart, has a programmable terminal value and a saturate-or-wrap mode, produces a
//   one-cycle terminal-count pulse, and decodes NWIN position windows.
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   clr        synchronous line restart (level-sensitive, beats en)
//   en         count enable (pixel strobe)
//   wrap       0 = saturate at limit, 1 = wrap to 0 after limit
//   limit      terminal count value
//   win_start  packed window starts, window i at [i*(DWIDTH+1) +: DWIDTH+1]
//   win_end    packed window ends (exclusive), same packing
//   counter    registered position
//   sat        counter held at terminal value
//   tc         one-cycle terminal-count pulse (registered)
//   in_win     per-window hit, combinational from registered counter

// Single window comparator. An end at or below the start gives an empty window
// because no value can satisfy both compares.
module sync_span_win #(
  parameter int W = 9
) (
  input  logic [W-1:0] counter,
  input  logic [W-1:0] start,
  input  logic [W-1:0] stop,
  output logic         hit
);
  assign hit = (counter >= start) && (counter < stop);
endmodule

module sync_span_counter #(
  parameter int DWIDTH = 8,
  parameter int NWIN   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     wrap,
  input  logic [DWIDTH:0]          limit,
  input  logic [NWIN*(DWIDTH+1)-1:0] win_start,
  input  logic [NWIN*(DWIDTH+1)-1:0] win_end,
  output logic [DWIDTH:0]          counter,
  output logic                     sat,
  output logic                     tc,
  output logic [NWIN-1:0]          in_win
);
  localparam int W = DWIDTH + 1;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
  state_t state;

  // Increment only happens when counter < limit, so counter+1 never overflows
  // even with limit at all-ones; no carry bit is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= '0;
      sat     <= 1'b0;
      tc      <= 1'b0;
      state   <= RUN;
    end else if (clr) begin
      counter <= '0;
      sat     <= 1'b0;
      tc      <= 1'b0;
      state   <= RUN;
    end else if (en) begin
      case (state)
        RUN: begin
          if (counter < limit) begin
            counter <= counter + ONE;
            tc      <= 1'b0;
          end else if (wrap) begin
            // >= also catches a limit lowered below the current position
            counter <= '0;
            tc      <= 1'b1;
          end else begin
            counter <= limit;
            sat     <= 1'b1;
            tc      <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          tc <= 1'b0;
          // switching to wrap mode releases the hold without a terminal pulse
          if (wrap) begin
            counter <= '0;
            sat     <= 1'b0;
            state   <= RUN;
          end
        end
        default: begin
          counter <= '0;
          sat     <= 1'b0;
          tc      <= 1'b0;
          state   <= RUN;
        end
      endcase
    end else begin
      tc <= 1'b0;
    end
  end

  for (genvar i = 0; i < NWIN; i++) begin : g_win
    sync_span_win #(.W(W)) u_win (
      .counter (counter),
      .start   (win_start[i*W +: W]),
      .stop    (win_end[i*W +: W]),
      .hit     (in_win[i])
    );
  end
endmodule

// File: tb/tb_sync_span_counter.sv
module tb_sync_span_counter;
  localparam int DW = 8;
  localparam int NW = 2;
  localparam int W  = DW + 1;

  logic clk = 1'b0;
  logic rst_n, clr, en, wrap;
  logic [W-1:0] limit;
  logic [NW*W-1:0] win_start, win_end;
  logic [W-1:0] counter;
  logic sat, tc;
  logic [NW-1:0] in_win;

  always #5 clk = ~clk;

  sync_span_counter #(.DWIDTH(DW), .NWIN(NW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .wrap(wrap), .limit(limit),
    .win_start(win_start), .win_end(win_end),
    .counter(counter), .sat(sat), .tc(tc), .in_win(in_win)
  );

  typedef struct {
    logic rst_n, clr, en, wrap;
    logic [W-1:0] limit, ws0, we0, ws1, we1;
    logic [W-1:0] e_cnt;
    logic e_sat, e_tc;
    logic [1:0] e_win;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_fail = 0;

  // current window setup for vectors being added
  logic [W-1:0] cs0 = 9'd2, ce0 = 9'd5, cs1 = 9'd5, ce1 = 9'd5;

  function automatic logic hitf(logic [W-1:0] c, logic [W-1:0] s, logic [W-1:0] e);
    return (c >= s) && (c < e);
  endfunction

  task automatic add(input logic r, input logic c, input logic e, input logic w,
                     input int lim, input int ecnt, input logic esat, input logic etc);
    vec_t v;
    v.rst_n = r; v.clr = c; v.en = e; v.wrap = w; v.limit = W'(lim);
    v.ws0 = cs0; v.we0 = ce0; v.ws1 = cs1; v.we1 = ce1;
    v.e_cnt = W'(ecnt); v.e_sat = esat; v.e_tc = etc;
    v.e_win = {hitf(W'(ecnt), cs1, ce1), hitf(W'(ecnt), cs0, ce0)};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic e, input logic w,
                       input int lim);
    @(negedge clk);
    rst_n = r; clr = c; en = e; wrap = w; limit = W'(lim);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input int idx, input int ecnt, input logic esat, input logic etc);
    chk("counter", idx, int'(counter), ecnt);
    chk("sat", idx, int'(sat), int'(esat));
    chk("tc", idx, int'(tc), int'(etc));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; wrap = 1'b0; limit = '0;
    win_start = '0; win_end = '0;

    // 1: reset with en high, window 0 = [4,8)
    cs0 = 9'd4; ce0 = 9'd8;
    add(0, 0, 1, 0, 5, 0, 0, 0);
    add(0, 0, 1, 0, 5, 0, 0, 0);
    cs0 = 9'd2; ce0 = 9'd5;

    // 2: saturate at 5, then held 20 cycles
    for (int i = 1; i <= 5; i++) add(1, 0, 1, 0, 5, i, 0, 0);
    add(1, 0, 1, 0, 5, 5, 1, 1);
    for (int i = 0; i < 20; i++) add(1, 0, 1, 0, 5, 5, 1, 0);
    // 4b: clr while held, then counting resumes
    add(1, 1, 1, 0, 5, 0, 0, 0);
    add(1, 0, 1, 0, 5, 1, 0, 0);

    // 3: wrap at 3
    add(1, 1, 0, 1, 3, 0, 0, 0);
    add(1, 0, 1, 1, 3, 1, 0, 0);
    add(1, 0, 1, 1, 3, 2, 0, 0);
    add(1, 0, 1, 1, 3, 3, 0, 0);
    add(1, 0, 1, 1, 3, 0, 0, 1);
    add(1, 0, 1, 1, 3, 1, 0, 0);
    add(1, 0, 1, 1, 3, 2, 0, 0);
    add(1, 0, 1, 1, 3, 3, 0, 0);
    add(1, 0, 1, 1, 3, 0, 0, 1);
    add(1, 0, 0, 1, 3, 0, 0, 0);
    add(1, 0, 1, 1, 3, 1, 0, 0);
    add(1, 0, 0, 1, 3, 1, 0, 0);
    add(1, 0, 1, 1, 3, 2, 0, 0);
    add(1, 0, 0, 1, 3, 2, 0, 0);

    // 4a: counter 7, clr and en together
    add(1, 1, 0, 0, 20, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 0, 1, 0, 20, i, 0, 0);
    add(1, 1, 1, 0, 20, 0, 0, 0);

    // 5: at 10, limit lowered to 6, then wrap releases hold
    for (int i = 1; i <= 10; i++) add(1, 0, 1, 0, 20, i, 0, 0);
    add(1, 0, 1, 0, 6, 6, 1, 1);
    add(1, 0, 1, 1, 6, 0, 0, 0);
    add(1, 0, 1, 1, 6, 1, 0, 0);

    // limit = 0, saturate then wrap
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0);

    // 6: full sweep to all-ones with windows [2,5) and [5,5)
    add(1, 1, 0, 0, 511, 0, 0, 0);
    for (int i = 1; i <= 511; i++) add(1, 0, 1, 0, 511, i, 0, 0);
    add(1, 0, 1, 0, 511, 511, 1, 1);
    add(1, 0, 1, 0, 511, 511, 1, 0);

    foreach (vq[k]) begin
      @(negedge clk);
      rst_n = vq[k].rst_n; clr = vq[k].clr; en = vq[k].en; wrap = vq[k].wrap;
      limit = vq[k].limit;
      win_start = {vq[k].ws1, vq[k].ws0};
      win_end   = {vq[k].we1, vq[k].we0};
      @(posedge clk);
      #1;
      check_now(k, int'(vq[k].e_cnt), vq[k].e_sat, vq[k].e_tc);
      chk("in_win", k, int'(in_win), int'(vq[k].e_win));
    end

    // Hand sequence: held state ignores en=0 and a raised limit while wrap=0
    drive(1, 1, 0, 0, 2);  check_now(1000, 0, 0, 0);
    drive(1, 0, 1, 0, 2);  check_now(1001, 1, 0, 0);
    drive(1, 0, 1, 0, 2);  check_now(1002, 2, 0, 0);
    drive(1, 0, 1, 0, 2);  check_now(1003, 2, 1, 1);
    drive(1, 0, 0, 0, 2);  check_now(1004, 2, 1, 0);
    drive(1, 0, 0, 0, 9);  check_now(1005, 2, 1, 0);
    drive(1, 0, 1, 0, 9);  check_now(1006, 2, 1, 0);
    // reset beats clr and en mid-hold
    drive(0, 1, 1, 1, 9);  check_now(1007, 0, 0, 0);
    drive(1, 0, 1, 0, 9);  check_now(1008, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
